// File: rtl/clk_div_pkg.sv
//------------------------------------------------------------------------------
// clk_div_pkg : shared CLK-domain parameters (ratio width, bypass threshold)
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package clk_div_pkg;

  localparam int unsigned RATIO_WD_DEF = 8;
  localparam int unsigned BYPASS_THR   = 2;

endpackage

`default_nettype wire

// File: rtl/clk_div_clk_mux.sv
//------------------------------------------------------------------------------
// clk_mux : bypass select between the reference clock and the divided clock
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clk_mux (
  input  logic i_clk,
  input  logic i_div,
  input  logic i_bypass,
  output logic o_clk
);

  // Kept as its own cell so it can be mapped to a library clock mux
  assign o_clk = i_bypass ? i_clk : i_div;

endmodule

`default_nettype wire

// File: rtl/clk_div.sv
//------------------------------------------------------------------------------
// clk_div : integer clock divider, low phase ceil(N/2), high phase floor(N/2)
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clk_div
  import clk_div_pkg::*;
#(
  parameter int unsigned RATIO_WD = RATIO_WD_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                i_clk_en,
  input  logic [RATIO_WD-1:0] i_div_ratio,
  output logic                o_div_clk
);

  logic [RATIO_WD-1:0] ratio_q, ratio_d;
  logic [RATIO_WD-1:0] cnt_q, cnt_d;
  logic                div_q, div_d;
  logic                run_q, run_d;
  logic [RATIO_WD-1:0] phase_len;
  logic                ratio_low;
  logic                bypass;

  assign ratio_low = (ratio_q < RATIO_WD'(BYPASS_THR));
  assign bypass    = !i_clk_en || ratio_low;

  // Low phase carries the extra cycle of an odd ratio
  assign phase_len = div_q ? (ratio_q >> 1)
                           : ((ratio_q >> 1) + {{(RATIO_WD-1){1'b0}}, ratio_q[0]});

  always_comb begin
    ratio_d = ratio_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    run_d   = run_q;
    if (!i_clk_en) begin
      run_d = 1'b0;
      cnt_d = '0;
      div_d = 1'b0;
    end else if (!run_q || ratio_low) begin
      // Start-up load, or keep re-sampling while the active ratio is too small
      run_d   = 1'b1;
      ratio_d = i_div_ratio;
      cnt_d   = '0;
      div_d   = 1'b0;
    end else if (cnt_q == phase_len - RATIO_WD'(1)) begin
      cnt_d = '0;
      div_d = ~div_q;
      if (div_q) begin
        ratio_d = i_div_ratio;
      end
    end else begin
      cnt_d = cnt_q + RATIO_WD'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ratio_q <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      ratio_q <= ratio_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      run_q   <= run_d;
    end
  end

  clk_mux u_clk_mux (
    .i_clk    (CLK),
    .i_div    (div_q),
    .i_bypass (bypass),
    .o_clk    (o_div_clk)
  );

endmodule

`default_nettype wire

// File: tb/tb_clk_div.sv
//------------------------------------------------------------------------------
// tb_clk_div : directed self-checking bench for clk_div
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_clk_div;

  logic       CLK = 1'b0;
  logic       RST;
  logic       i_clk_en;
  logic [7:0] i_div_ratio;
  logic       o_div_clk;

  int n_cmp = 0;
  int n_err = 0;

  clk_div #(.RATIO_WD(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .i_clk_en    (i_clk_en),
    .i_div_ratio (i_div_ratio),
    .o_div_clk   (o_div_clk)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Land 1 time unit after the falling edge: low half of CLK, state of last posedge
  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic expect_run(input string tag, input logic val, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check(tag, o_div_clk, val);
    end
  endtask

  task automatic expect_div(input string tag, input int lo, input int hi, input int periods);
    for (int p = 0; p < periods; p++) begin
      expect_run(tag, 1'b0, lo);
      expect_run(tag, 1'b1, hi);
    end
  endtask

  // In bypass the output must be high in the high half and low in the low half
  task automatic check_bypass(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      check(tag, o_div_clk, 1'b1);
      step();
      check(tag, o_div_clk, 1'b0);
    end
  endtask

  initial begin
    RST         = 1'b0;
    i_clk_en    = 1'b1;
    i_div_ratio = 8'd8;

    check_bypass("rst_bypass", 2);
    RST = 1'b1;
    expect_div("div8", 4, 4, 2);

    i_div_ratio = 8'd5;
    expect_div("div5", 3, 2, 2);
    i_div_ratio = 8'd2;
    expect_div("div2", 1, 1, 3);
    i_div_ratio = 8'd255;
    expect_div("div255", 128, 127, 1);

    // Ratio change mid-high phase only lands at the next period boundary
    i_div_ratio = 8'd8;
    expect_run("chg_keep8", 1'b0, 4);
    expect_run("chg_keep8", 1'b1, 2);
    i_div_ratio = 8'd4;
    expect_run("chg_keep8", 1'b1, 2);
    expect_div("chg_to4", 2, 2, 2);

    i_div_ratio = 8'd0;
    check_bypass("ratio0", 3);
    i_div_ratio = 8'd1;
    check_bypass("ratio1", 3);
    i_div_ratio = 8'd6;
    expect_div("div6", 3, 3, 2);

    // Enable dropped in the third low cycle while CLK is high
    expect_run("en_pre", 1'b0, 2);
    @(posedge CLK);
    #1;
    i_clk_en = 1'b0;
    #1;
    check("en_drop_imm", o_div_clk, 1'b1);
    step();
    check("en_drop_lo", o_div_clk, 1'b0);
    check_bypass("en_off", 2);
    i_clk_en = 1'b1;
    expect_div("en_reload", 3, 3, 1);

    // Reset pulse mid-high phase of ratio 8
    i_div_ratio = 8'd8;
    expect_run("rst_pre", 1'b0, 4);
    expect_run("rst_pre", 1'b1, 2);
    RST = 1'b0;
    #1;
    check("rst_imm", o_div_clk, 1'b0);
    check_bypass("rst_mid", 2);
    RST = 1'b1;
    expect_div("rst_after", 4, 4, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clk_div.md
CLK_DIV -- requirements
Module: clk_div

Interface
REQ-001 Parameter RATIO_WD, default 8, width of the division-ratio input and internal counter.
REQ-002 CLK  input  1  reference clock; all sequential logic on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-low; driven from the reset-synchronizer output of the CLK domain, so deassertion is CLK-synchronous.
REQ-004 i_clk_en  input  1  divider enable; low selects bypass.
REQ-005 i_div_ratio  input  RATIO_WD  requested integer ratio N; quasi-static, sampled only at defined points.
REQ-006 o_div_clk  output  1  divided clock (or CLK in bypass).

Function
REQ-007 Shadow register ratio_q shall hold the active ratio; i_div_ratio is never used directly by counter or output logic.
REQ-008 Bypass shall be active when i_clk_en=0 or ratio_q<2; in bypass o_div_clk shall equal CLK.
REQ-009 Internal flag run_q shall be 0 while i_clk_en=0 and shall set on the first CLK edge with i_clk_en=1; that same edge shall load ratio_q<=i_div_ratio, clear the counter, and set div_q=0.
REQ-010 In divided mode each o_div_clk period shall be exactly N CLK cycles: low phase ceil(N/2) cycles followed by high phase floor(N/2) cycles.
REQ-011 Even N: 50% duty. Odd N: low one cycle longer than high (N=3 -> 2 low, 1 high).
REQ-012 Counter cnt_q shall count 0..phase_len-1 within each phase, clear on phase end, and toggle div_q on that same edge.
REQ-013 o_div_clk shall be driven from register div_q (no combinational path from counter) when not in bypass.
REQ-014 Period boundary = the edge on which div_q goes 1->0; on that edge ratio_q shall reload from i_div_ratio, so a ratio change takes effect at the start of the next period, never mid-period.
REQ-015 If the reloaded ratio is <2, the block shall enter bypass from the next cycle and keep cnt_q=0, div_q=0.
REQ-016 If the reloaded ratio is >=2 while bypass was caused by ratio_q<2 (i_clk_en=1), reload shall occur every CLK edge until ratio_q>=2, then divided mode starts with a full low phase.
REQ-017 i_clk_en falling mid-period: bypass immediately (combinational select); on the next CLK edge run_q, cnt_q, div_q shall clear.
REQ-018 i_clk_en re-asserted: behaviour per REQ-009; the first o_div_clk rising edge occurs ceil(N/2) CLK edges after the loading edge.
REQ-019 Counter width RATIO_WD shall cover the maximum ratio 2^RATIO_WD-1 with no overflow or wrap.

Reset
REQ-020 RST low shall asynchronously clear ratio_q, cnt_q, div_q, run_q to 0.
REQ-021 During reset o_div_clk shall equal CLK (bypass, since ratio_q=0).
REQ-022 After RST deasserts with i_clk_en=1, behaviour shall follow REQ-009 from the first CLK edge.
REQ-023 Reset asserted mid-period shall abandon the period with no partial-phase completion after release.

Structure
REQ-024 RATIO_WD default and the bypass threshold (2) shall live in the shared system parameter package used by all CLK-domain blocks.
REQ-025 The bypass selection shall be instantiated as one sub-module, clk_mux (CLK / div_q select), so that synthesis can map it to a library clock-mux cell and DFT can constrain it; all remaining logic is flat in clk_div.
REQ-026 o_div_clk shall be declared a generated clock (divide-by-ratio of CLK) in the block constraints.

Verification
REQ-027 RST low, i_clk_en=1, ratio=8; release -> o_div_clk low 4 cycles, high 4 cycles, repeating period 8.
REQ-028 ratio=5 -> low 3 / high 2, period 5; ratio=2 -> 1/1; ratio=255 -> 128/127 with no counter wrap.
REQ-029 ratio 8 changed to 4 mid-high-phase -> current period completes as 8, next period is 2 low / 2 high.
REQ-030 ratio=0 and ratio=1 -> o_div_clk identical to CLK; change to 6 -> first divided period is 3 low / 3 high.
REQ-031 i_clk_en dropped at cycle 3 of ratio=6 -> o_div_clk follows CLK immediately; re-enable -> fresh 3-low phase after the load edge.
REQ-032 RST pulsed low mid-high-phase -> o_div_clk follows CLK during reset; after release, a full 4-low phase (ratio=8) is observed.
